wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 64, data width of results and regfile write port.
REQ-002 Parameter DEPTH, default 2, entries per source FIFO (power of two, >=2).
REQ-003 Parameter STARVE_LIMIT, default 3, consecutive lost arbitrations before the ALU port is forced to win.
REQ-004 i_clk  input  1  single clock; all state on rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_alu_valid  input  1  ALU result offered.
REQ-007 o_alu_ready  output  1  ALU FIFO can accept; a transfer occurs when valid&&ready.
REQ-008 i_alu_rd  input  5  ALU destination register.
REQ-009 i_alu_data  input  XLEN  ALU result.
REQ-010 i_ld_valid  input  1  load result offered.
REQ-011 o_ld_ready  output  1  load FIFO can accept.
REQ-012 i_ld_rd  input  5  load destination register.
REQ-013 i_ld_data  input  XLEN  load result.
REQ-014 o_we  output  1  regfile write enable, registered.
REQ-015 o_rd  output  5  regfile write address, registered.
REQ-016 o_data  output  XLEN  regfile write data, registered.
REQ-017 o_pending  output  1  high when either FIFO holds an entry.

Function
REQ-018 Each port SHALL own an independent DEPTH-entry FIFO storing {rd, data}, with pointers wrapping modulo DEPTH.
REQ-019 o_x_ready SHALL equal "FIFO not full" from registered state only; it SHALL have no combinational dependence on a same-cycle pop.
REQ-020 A push into a full FIFO SHALL NOT occur; push and pop in the same cycle on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-021 At most one entry SHALL be popped per cycle, across both FIFOs.
REQ-022 Arbitration: if only one FIFO is non-empty, it SHALL be popped.
REQ-023 If both FIFOs are non-empty, the load FIFO SHALL win unless starve_cnt == STARVE_LIMIT, in which case the ALU FIFO SHALL win.
REQ-024 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle the ALU FIFO is non-empty and not popped, and clear to 0 on any ALU pop or whenever the ALU FIFO is empty.
REQ-025 A popped entry SHALL appear on o_rd/o_data in the following cycle with o_we=1 (latency: input handshake -> o_we is 2 cycles minimum for an empty block).
REQ-026 A popped entry with rd==0 SHALL be discarded: o_we=0 that cycle, with o_rd/o_data holding their previous values.
REQ-027 In cycles with no pop, o_we SHALL be 0 and o_rd/o_data SHALL hold.
REQ-028 Entries from one port SHALL retire in acceptance order; no ordering is guaranteed between ports.
REQ-029 o_pending SHALL be the OR of both FIFO non-empty flags (registered state).

Reset
REQ-030 While i_reset is high: both FIFOs empty, pointers 0, starve_cnt 0, o_we 0, o_rd 0, o_data 0, o_pending 0, both readys 1.
REQ-031 Assertion mid-operation SHALL discard all queued entries immediately, without emitting a write; the first push after deassertion SHALL be accepted on the first clock edge.

Verification
REQ-032 Single ALU push rd=5, data=0x1234 into an idle block -> o_we=1, o_rd=5, o_data=0x1234 exactly 2 edges later, then o_we=0.
REQ-033 ALU push rd=0, data=0xFF -> FIFO drains, o_we stays 0, o_pending returns to 0.
REQ-034 Both ports valid every cycle with distinct rd -> pattern of 3 load writes then 1 ALU write, repeating; no entry is lost or reordered within a port.
REQ-035 Hold o_we side stalled by continuous load traffic and push 3 ALU entries -> o_alu_ready=0 after 2 accepts (DEPTH=2), and returns to 1 the cycle after the first ALU pop.
REQ-036 Fill both FIFOs, assert i_reset for 1 cycle -> o_we=0 with no writes emitted, o_pending=0, readys=1; the next ALU push rd=7 is written 2 edges later.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load results into a single registered regfile write port.
// Latency: one edge from FIFO pop to o_we, so two edges from input handshake to o_we on an idle block.
// Backpressure: each port has its own FIFO. The port's ready is "FIFO not full" and is taken from registered pointers.
//
// Ports:
//   i_clk, i_reset (async, active-high)
//   i_alu_valid/o_alu_ready/i_alu_rd/i_alu_data : ALU result stream
//   i_ld_valid/o_ld_ready/i_ld_rd/i_ld_data     : load result stream
//   o_we/o_rd/o_data                            : registered regfile write port
//   o_pending                                   : either FIFO holds an entry

// wb_fifo: generic DEPTH-entry FIFO with registered full/empty flags.
// Latency: a push is visible at the output on the next edge. pop_dat always shows the head entry.
// Backpressure: pushes while full and pops while empty are ignored.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // An extra wrap bit tells full and empty apart.
    // The low bits index the storage modulo DEPTH.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_vld && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_alu_valid,
    output logic            o_alu_ready,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic            i_ld_valid,
    output logic            o_ld_ready,
    input  logic [4:0]      i_ld_rd,
    input  logic [XLEN-1:0] i_ld_data,
    output logic            o_we,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_data,
    output logic            o_pending
);
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    localparam int            SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    wb_entry_t     alu_push_dat;
    wb_entry_t     ld_push_dat;
    wb_entry_t     alu_pop_dat;
    wb_entry_t     ld_pop_dat;
    wb_entry_t     win_dat;
    logic          alu_full;
    logic          alu_empty;
    logic          ld_full;
    logic          ld_empty;
    logic          alu_pop;
    logic          ld_pop;
    logic [SW-1:0] starve_cnt;

    assign alu_push_dat = {i_alu_rd, i_alu_data};
    assign ld_push_dat  = {i_ld_rd, i_ld_data};

    wb_fifo #(.WIDTH($bits(wb_entry_t)), .DEPTH(DEPTH)) u_alu_fifo (
        .clk      (i_clk),
        .rst      (i_reset),
        .push_vld (i_alu_valid),
        .push_dat (alu_push_dat),
        .pop_vld  (alu_pop),
        .pop_dat  (alu_pop_dat),
        .full     (alu_full),
        .empty    (alu_empty)
    );

    wb_fifo #(.WIDTH($bits(wb_entry_t)), .DEPTH(DEPTH)) u_ld_fifo (
        .clk      (i_clk),
        .rst      (i_reset),
        .push_vld (i_ld_valid),
        .push_dat (ld_push_dat),
        .pop_vld  (ld_pop),
        .pop_dat  (ld_pop_dat),
        .full     (ld_full),
        .empty    (ld_empty)
    );

    // Readiness comes only from registered pointers.
    // A pop in the same cycle does not free a slot until the next edge.
    assign o_alu_ready = !alu_full;
    assign o_ld_ready  = !ld_full;
    assign o_pending   = !alu_empty || !ld_empty;

    // Loads normally win a tie because a dependent instruction is usually waiting on them.
    // Once the ALU has lost STARVE_LIMIT times in a row, the ALU wins.
    always_comb begin
        ld_pop  = !ld_empty && (alu_empty || (starve_cnt != STARVE_MAX));
        alu_pop = !alu_empty && !ld_pop;
        win_dat = ld_pop ? ld_pop_dat : alu_pop_dat;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            starve_cnt <= '0;
            o_we       <= 1'b0;
            o_rd       <= '0;
            o_data     <= '0;
        end else begin
            if (alu_empty || alu_pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            // An entry for x0 is still popped, but it is dropped.
            // o_rd and o_data keep their previous values.
            o_we <= 1'b0;
            if ((alu_pop || ld_pop) && (win_dat.rd != 5'd0)) begin
                o_we   <= 1'b1;
                o_rd   <= win_dat.rd;
                o_data <= win_dat.data;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    localparam int XLEN = 64;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_alu_valid = 1'b0;
    logic            o_alu_ready;
    logic [4:0]      i_alu_rd = '0;
    logic [XLEN-1:0] i_alu_data = '0;
    logic            i_ld_valid = 1'b0;
    logic            o_ld_ready;
    logic [4:0]      i_ld_rd = '0;
    logic [XLEN-1:0] i_ld_data = '0;
    logic            o_we;
    logic [4:0]      o_rd;
    logic [XLEN-1:0] o_data;
    logic            o_pending;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t alu_q[$];
    ent_t ld_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic a_acc;
    logic l_acc;

    wb_arbiter #(.XLEN(XLEN), .DEPTH(2), .STARVE_LIMIT(3)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_alu_valid (i_alu_valid),
        .o_alu_ready (o_alu_ready),
        .i_alu_rd    (i_alu_rd),
        .i_alu_data  (i_alu_data),
        .i_ld_valid  (i_ld_valid),
        .o_ld_ready  (o_ld_ready),
        .i_ld_rd     (i_ld_rd),
        .i_ld_data   (i_ld_data),
        .o_we        (o_we),
        .o_rd        (o_rd),
        .o_data      (o_data),
        .o_pending   (o_pending)
    );

    always #5 i_clk = ~i_clk;

    // Called on a falling edge.
    // Drives one cycle of stimulus and records accepted non-x0 entries as expected writes.
    // Then waits for the next falling edge, so the outputs reflect the rising edge in between.
    task automatic tick(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] adat,
                        input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldat);
        ent_t e;
        i_alu_valid = av;
        i_alu_rd    = ard;
        i_alu_data  = adat;
        i_ld_valid  = lv;
        i_ld_rd     = lrd;
        i_ld_data   = ldat;
        a_acc = av && o_alu_ready;
        l_acc = lv && o_ld_ready;
        if (a_acc && ard != 5'd0) begin
            e.rd = ard; e.data = adat; alu_q.push_back(e);
        end
        if (l_acc && lrd != 5'd0) begin
            e.rd = lrd; e.data = ldat; ld_q.push_back(e);
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        n_checks++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", o_we); end
        n_checks++; if (o_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", o_rd); end
        n_checks++; if (o_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_data); end
        n_checks++; if (o_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", o_pending); end
        n_checks++; if (o_alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alu_ready: got %b want 1", o_alu_ready); end
        n_checks++; if (o_ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 1", o_ld_ready); end
        i_reset = 1'b0;
    endtask

    task automatic test_single;
        ent_t e;
        tick(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, '0);
        n_checks++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL single_early_we: got %b want 0", o_we); end
        n_checks++; if (o_pending !== 1'b1) begin n_fail++; $display("FAIL single_pending: got %b want 1", o_pending); end
        tick(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        n_checks++; if (o_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", o_we); end
        n_checks++; if (o_rd !== 5'd5) begin n_fail++; $display("FAIL single_rd: got %0d want 5", o_rd); end
        n_checks++; if (o_data !== 64'h1234) begin n_fail++; $display("FAIL single_data: got %h want 1234", o_data); end
        n_checks++;
        if (alu_q.size() == 0) begin
            n_fail++; $display("FAIL single_sb: write rd=%0d with nothing expected", o_rd);
        end else begin
            e = alu_q.pop_front();
            if (e.rd !== o_rd || e.data !== o_data) begin
                n_fail++; $display("FAIL single_sb: got rd=%0d data=%h want rd=%0d data=%h", o_rd, o_data, e.rd, e.data);
            end
        end
        tick(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        n_checks++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL single_we_drop: got %b want 0", o_we); end
        n_checks++; if (o_rd !== 5'd5) begin n_fail++; $display("FAIL single_rd_hold: got %0d want 5", o_rd); end
        n_checks++; if (o_pending !== 1'b0) begin n_fail++; $display("FAIL single_pending_clr: got %b want 0", o_pending); end
    endtask

    task automatic test_rd_zero;
        tick(1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, '0);
        n_checks++; if (o_pending !== 1'b1) begin n_fail++; $display("FAIL rd0_pending: got %b want 1", o_pending); end
        tick(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        n_checks++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL rd0_we: got %b want 0", o_we); end
        n_checks++; if (o_rd !== 5'd5) begin n_fail++; $display("FAIL rd0_rd_hold: got %0d want 5", o_rd); end
        n_checks++; if (o_data !== 64'h1234) begin n_fail++; $display("FAIL rd0_data_hold: got %h want 1234", o_data); end
        tick(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        n_checks++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL rd0_we_late: got %b want 0", o_we); end
        n_checks++; if (o_pending !== 1'b0) begin n_fail++; $display("FAIL rd0_pending_clr: got %b want 0", o_pending); end
    endtask

    // Both ports offer data on every cycle.
    // ALU entries use rd 1..15 and load entries use rd 16..31, so rd[4] identifies the source.
    task automatic test_back_to_back;
        ent_t e;
        int   wr_idx;
        int   ak;
        int   lk;
        logic act;
        logic src_alu;
        logic exp_alu;
        wr_idx = 0; ak = 0; lk = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            act = (cyc < 24);
            tick(act, 5'(1 + ak % 15), {$urandom(), $urandom()}, act, 5'(16 + lk % 16), {$urandom(), $urandom()});
            if (a_acc) ak++;
            if (l_acc) lk++;
            if (o_we === 1'b1) begin
                src_alu = !o_rd[4];
                if (wr_idx < 16) begin
                    exp_alu = (wr_idx % 4 == 3);
                    n_checks++;
                    if (src_alu !== exp_alu) begin
                        n_fail++; $display("FAIL b2b_order: write %0d from alu=%0b want alu=%0b", wr_idx, src_alu, exp_alu);
                    end
                end
                n_checks++;
                if ((src_alu ? alu_q.size() : ld_q.size()) == 0) begin
                    n_fail++; $display("FAIL b2b_sb: unexpected write rd=%0d data=%h", o_rd, o_data);
                end else begin
                    e = src_alu ? alu_q.pop_front() : ld_q.pop_front();
                    if (e.rd !== o_rd || e.data !== o_data) begin
                        n_fail++; $display("FAIL b2b_sb: got rd=%0d data=%h want rd=%0d data=%h", o_rd, o_data, e.rd, e.data);
                    end
                end
                wr_idx++;
            end
            if (cyc >= 24 && o_pending === 1'b0 && o_we === 1'b0) break;
        end
        n_checks++; if (wr_idx < 16) begin n_fail++; $display("FAIL b2b_count: got %0d writes want at least 16", wr_idx); end
        n_checks++; if (alu_q.size() != 0) begin n_fail++; $display("FAIL b2b_alu_lost: %0d entries never written, want 0", alu_q.size()); end
        n_checks++; if (ld_q.size() != 0) begin n_fail++; $display("FAIL b2b_ld_lost: %0d entries never written, want 0", ld_q.size()); end
        n_checks++; if (o_pending !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: pending=%b want 0", o_pending); end
    endtask

    // Continuous load traffic keeps the ALU FIFO stalled while three ALU entries are offered.
    task automatic test_backpressure;
        ent_t a_src[3];
        ent_t e;
        logic exp_rdy[5];
        int   ai;
        int   lk;
        int   idx;
        logic lact;
        logic aact;
        logic src_alu;
        a_src[0].rd = 5'd3; a_src[0].data = 64'hA0A0_0000_0000_0003;
        a_src[1].rd = 5'd4; a_src[1].data = 64'hA1A1_0000_0000_0004;
        a_src[2].rd = 5'd6; a_src[2].data = 64'hA2A2_0000_0000_0006;
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        ai = 0; lk = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            lact = (cyc < 12);
            aact = (ai < 3);
            idx  = aact ? ai : 0;
            tick(aact, aact ? a_src[idx].rd : 5'd0, aact ? a_src[idx].data : '0,
                 lact, 5'(16 + lk % 16), {$urandom(), $urandom()});
            if (a_acc) ai++;
            if (l_acc) lk++;
            if (cyc < 5) begin
                n_checks++;
                if (o_alu_ready !== exp_rdy[cyc]) begin
                    n_fail++; $display("FAIL bp_ready_c%0d: got %b want %b", cyc, o_alu_ready, exp_rdy[cyc]);
                end
            end
            if (cyc >= 1 && cyc <= 3) begin
                n_checks++;
                if (o_we !== 1'b1 || o_rd[4] !== 1'b1) begin
                    n_fail++; $display("FAIL bp_load_first_c%0d: got we=%b rd=%0d want a load write", cyc, o_we, o_rd);
                end
            end
            if (cyc == 4) begin
                n_checks++;
                if (o_we !== 1'b1 || o_rd !== a_src[0].rd) begin
                    n_fail++; $display("FAIL bp_alu_pop: got we=%b rd=%0d want we=1 rd=%0d", o_we, o_rd, a_src[0].rd);
                end
            end
            if (o_we === 1'b1) begin
                src_alu = !o_rd[4];
                n_checks++;
                if ((src_alu ? alu_q.size() : ld_q.size()) == 0) begin
                    n_fail++; $display("FAIL bp_sb: unexpected write rd=%0d data=%h", o_rd, o_data);
                end else begin
                    e = src_alu ? alu_q.pop_front() : ld_q.pop_front();
                    if (e.rd !== o_rd || e.data !== o_data) begin
                        n_fail++; $display("FAIL bp_sb: got rd=%0d data=%h want rd=%0d data=%h", o_rd, o_data, e.rd, e.data);
                    end
                end
            end
            if (cyc >= 12 && ai == 3 && o_pending === 1'b0 && o_we === 1'b0) break;
        end
        n_checks++; if (ai != 3) begin n_fail++; $display("FAIL bp_accepts: got %0d ALU accepts want 3", ai); end
        n_checks++; if (alu_q.size() != 0) begin n_fail++; $display("FAIL bp_alu_lost: %0d entries never written, want 0", alu_q.size()); end
        n_checks++; if (ld_q.size() != 0) begin n_fail++; $display("FAIL bp_ld_lost: %0d entries never written, want 0", ld_q.size()); end
    endtask

    task automatic test_reset_flush;
        tick(1'b1, 5'd9, 64'h99, 1'b1, 5'd20, 64'h20);
        tick(1'b1, 5'd10, 64'h1010, 1'b1, 5'd21, 64'h21);
        i_alu_valid = 1'b0;
        i_ld_valid  = 1'b0;
        n_checks++; if (o_pending !== 1'b1) begin n_fail++; $display("FAIL flush_pre_pending: got %b want 1", o_pending); end
        i_reset = 1'b1;
        #1;
        n_checks++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL flush_we: got %b want 0", o_we); end
        n_checks++; if (o_pending !== 1'b0) begin n_fail++; $display("FAIL flush_pending: got %b want 0", o_pending); end
        n_checks++; if (o_alu_ready !== 1'b1) begin n_fail++; $display("FAIL flush_alu_ready: got %b want 1", o_alu_ready); end
        n_checks++; if (o_ld_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ld_ready: got %b want 1", o_ld_ready); end
        n_checks++; if (o_rd !== 5'd0 || o_data !== '0) begin n_fail++; $display("FAIL flush_out_clr: got rd=%0d data=%h want 0", o_rd, o_data); end
        @(negedge i_clk);
        n_checks++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL flush_we_held: got %b want 0", o_we); end
        i_reset = 1'b0;
        alu_q.delete();
        ld_q.delete();
        tick(1'b1, 5'd7, 64'hCAFE, 1'b0, 5'd0, '0);
        n_checks++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL flush_stale_we: got %b want 0", o_we); end
        tick(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        n_checks++;
        if (o_we !== 1'b1 || o_rd !== 5'd7 || o_data !== 64'hCAFE) begin
            n_fail++; $display("FAIL flush_first_push: got we=%b rd=%0d data=%h want we=1 rd=7 data=cafe", o_we, o_rd, o_data);
        end
        tick(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        n_checks++;
        if (o_we !== 1'b0 || o_pending !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: got we=%b pending=%b want 0 0", o_we, o_pending);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_rd_zero;
        test_back_to_back;
        test_backpressure;
        test_reset_flush;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "time limit");
    end
endmodule
